id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline stage between instruction decode and the 64-bit ALU of the pipelined LEGv8 datapath. Registers decoded operands and control from ID. Resolves EX-stage data hazards by forwarding from EX/MEM and MEM/WB. Drives `BusA`/`BusB`/`ALUCtrl` straight into the ALU, and detects load-use hazards so that it can stall ID and insert a bubble.

## Interface
Parameters:
- `XZR`, 5'd31, zero-register index; never a forwarding match and never a hazard match.

Ports:
- `Clk` in 1: rising-edge clock, the only clock.
- `Reset` in 1: synchronous, active-high.
- `IdValid` in 1: ID holds a real instruction.
- `IdRn`, `IdRm`, `IdRd` in 5 each: source/destination indices. `IdRm` is the second register actually read, after decode muxing.
- `IdRegOut1`, `IdRegOut2` in 64 each: register-file read data.
- `IdImm` in 64: sign-extended immediate.
- `IdALUSrc` in 1: 1 selects `IdImm` for ALU B.
- `IdALUCtrl` in 4: ALU operation code.
- `IdMemRead`, `IdMemWrite`, `IdRegWrite`, `IdMemToReg` in 1 each.
- `Flush` in 1: taken branch; kill the instruction entering EX.
- `ExMemRegWrite` in 1; `ExMemRd` in 5; `ExMemResult` in 64: EX/MEM forwarding source.
- `MemWbRegWrite` in 1; `MemWbRd` in 5; `MemWbData` in 64: MEM/WB forwarding source.
- `BusA`, `BusB` out 64: ALU operands.
- `ALUCtrl` out 4: ALU operation.
- `ExStoreData` out 64: forwarded second register value, used for stores.
- `ExValid`, `ExMemRead`, `ExMemWrite`, `ExRegWrite`, `ExMemToReg` out 1 each.
- `ExRd` out 5: destination index.
- `Stall` out 1: hold PC and IF/ID this cycle.

## Operation
- Registered state: valid, Rn, Rm, Rd, RegOut1, RegOut2, Imm, ALUSrc, ALUCtrl, and the four memory/writeback control bits.
- Update priority each edge:
  1. `Reset` loads the bubble.
  2. `Flush` loads the bubble.
  3. `Stall` loads the bubble.
  4. Otherwise the ID inputs are captured; the stored valid bit = `IdValid`.
- Bubble contents:
  - valid, all control bits and `ALUSrc` = 0.
  - `ALUCtrl` = 4'b0000.
  - Rn, Rm, Rd = `XZR`.
  - All 64-bit fields = 0.
- Load-use hazard (combinational): `Stall` = `IdValid` & stored valid & stored MemRead & stored Rd≠`XZR` & (stored Rd==`IdRn` | stored Rd==`IdRm`).
  - `Flush` does not mask `Stall`; the bubble is loaded either way.
- Forwarding for operand A (stored Rn vs. stored RegOut1), combinational:
  - If `ExMemRegWrite` & `ExMemRd`==Rn & Rn≠`XZR`, select `ExMemResult`.
  - Else if `MemWbRegWrite` & `MemWbRd`==Rn & Rn≠`XZR`, select `MemWbData`.
  - Else select stored RegOut1.
- Forwarding for operand B uses the same rule with Rm and RegOut2; the result is `ExStoreData`.
- `BusA` = forwarded A. `BusB` = stored ALUSrc ? stored Imm : `ExStoreData`.
- `ALUCtrl`, `ExRd` and the `Ex*` control bits are the registered values, passed through unchanged.
- Upstream stages clear their `RegWrite` for bubbles, so no valid qualification is applied to the forwarding sources.

## Timing
- Latency: ID inputs sampled at edge N appear on the outputs after edge N.
- The ALU result is valid in the same cycle; there is no extra pipeline delay.
- `Stall`, `BusA`, `BusB` and `ExStoreData` are combinational from registered state plus same-cycle inputs. No combinational path from `Id*` to `BusA`/`BusB`.
- Reset values:
  - `ExValid`, `ExMemRead`, `ExMemWrite`, `ExRegWrite`, `ExMemToReg`, `Stall` = 0.
  - `ALUCtrl` = 0.
  - `ExRd` = 31.
  - `BusA`, `BusB`, `ExStoreData` = 0, provided the forwarding sources are idle (their Rd fields equal `XZR` or their `RegWrite` bits are 0).
- Reset mid-stall: the bubble is loaded, and `Stall` drops in the next cycle.
- Simultaneous EX/MEM and MEM/WB match: EX/MEM wins.
- Back-to-back load-use: exactly one bubble per load. After the bubble, the dependent instruction is served by MEM/WB forwarding.

## Structure
- Shared header holds:
  - ALU code defines: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111.
  - `XZR` constant.
- Sub-module `operand_forward`: a 3-way priority mux with the match logic. Instantiated twice (A, B).
- Hazard detection and pipeline registers are written inline.

## Test plan
- Reset:
  - Stimulus: assert `Reset` for 2 cycles with the ID inputs non-zero.
  - Required: all outputs at reset values, `ExRd`=31.
- Forwarding priority:
  - Stimulus: ADD X1 enters EX; `ExMemRd`=1, `ExMemResult`=0x10 and `MemWbRd`=1, `MemWbData`=0x20, both `RegWrite`.
  - Required: `BusA`=0x10.
  - Stimulus: drop `ExMemRegWrite`.
  - Required: `BusA`=0x20.
- XZR never forwards:
  - Stimulus: Rn=31, `ExMemRd`=31, `ExMemRegWrite`=1, `ExMemResult`=0xFF, stored RegOut1=0.
  - Required: `BusA`=0.
- Load-use:
  - Stimulus: LDUR X2 sits in EX; ID has ADD with `IdRm`=2.
  - Required: `Stall`=1 for exactly one cycle; the next cycle has `ExValid`=0 and `ExRegWrite`=0.
- Flush:
  - Stimulus: `Flush`=1 with a valid STUR in ID.
  - Required: the next cycle has `ExMemWrite`=0 and `ExValid`=0.
- Immediate select:
  - Stimulus: `IdALUSrc`=1, `IdImm`=0x8, forwarded Rm value=0x55.
  - Required: `BusB`=0x8, `ExStoreData`=0x55.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU codes, zero-register index and the ID/EX register layout.
package id_ex_stage_pkg;
  localparam logic [4:0] XZR_REG = 5'd31;
  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_e;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
    logic [63:0] reg_out1;
    logic [63:0] reg_out2;
    logic [63:0] imm;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_reg_t;
  function automatic ex_reg_t bubble(input logic [4:0] zr);
    ex_reg_t b;
    b = '0;
    b.rn = zr;
    b.rm = zr;
    b.rd = zr;
    return b;
  endfunction
endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// operand_forward: picks EX/MEM, then MEM/WB, then the register-file value for one operand.
module operand_forward
  import id_ex_stage_pkg::*;
#(
  parameter logic [4:0] XZR = XZR_REG
) (
  input  logic [4:0]  idx,
  input  logic [63:0] reg_val,
  input  logic        ex_mem_we,
  input  logic [4:0]  ex_mem_rd,
  input  logic [63:0] ex_mem_val,
  input  logic        mem_wb_we,
  input  logic [4:0]  mem_wb_rd,
  input  logic [63:0] mem_wb_val,
  output logic [63:0] val
);
  logic live;
  assign live = idx != XZR;
  always_comb
    val = (live && ex_mem_we && ex_mem_rd == idx) ? ex_mem_val :
          (live && mem_wb_we && mem_wb_rd == idx) ? mem_wb_val : reg_val;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding and load-use stall detection.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter logic [4:0] XZR = XZR_REG
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IdValid,
  input  logic [4:0]  IdRn,
  input  logic [4:0]  IdRm,
  input  logic [4:0]  IdRd,
  input  logic [63:0] IdRegOut1,
  input  logic [63:0] IdRegOut2,
  input  logic [63:0] IdImm,
  input  logic        IdALUSrc,
  input  logic [3:0]  IdALUCtrl,
  input  logic        IdMemRead,
  input  logic        IdMemWrite,
  input  logic        IdRegWrite,
  input  logic        IdMemToReg,
  input  logic        Flush,
  input  logic        ExMemRegWrite,
  input  logic [4:0]  ExMemRd,
  input  logic [63:0] ExMemResult,
  input  logic        MemWbRegWrite,
  input  logic [4:0]  MemWbRd,
  input  logic [63:0] MemWbData,
  output logic [63:0] BusA,
  output logic [63:0] BusB,
  output logic [3:0]  ALUCtrl,
  output logic [63:0] ExStoreData,
  output logic        ExValid,
  output logic        ExMemRead,
  output logic        ExMemWrite,
  output logic        ExRegWrite,
  output logic        ExMemToReg,
  output logic [4:0]  ExRd,
  output logic        Stall
);
  ex_reg_t r, nxt;
  always_comb
    nxt = '{valid: IdValid, rn: IdRn, rm: IdRm, rd: IdRd, reg_out1: IdRegOut1,
            reg_out2: IdRegOut2, imm: IdImm, alu_src: IdALUSrc, alu_ctrl: IdALUCtrl,
            mem_read: IdMemRead, mem_write: IdMemWrite, reg_write: IdRegWrite,
            mem_to_reg: IdMemToReg};
  always_ff @(posedge Clk)
    r <= (Reset || Flush || Stall) ? bubble(XZR) : nxt;
  // A load in EX cannot forward its data yet, so a dependent ID instruction waits one cycle.
  assign Stall = IdValid && r.valid && r.mem_read && r.rd != XZR &&
                 (r.rd == IdRn || r.rd == IdRm);
  operand_forward #(.XZR(XZR)) u_fwd_a (
    .idx(r.rn), .reg_val(r.reg_out1),
    .ex_mem_we(ExMemRegWrite), .ex_mem_rd(ExMemRd), .ex_mem_val(ExMemResult),
    .mem_wb_we(MemWbRegWrite), .mem_wb_rd(MemWbRd), .mem_wb_val(MemWbData),
    .val(BusA)
  );
  operand_forward #(.XZR(XZR)) u_fwd_b (
    .idx(r.rm), .reg_val(r.reg_out2),
    .ex_mem_we(ExMemRegWrite), .ex_mem_rd(ExMemRd), .ex_mem_val(ExMemResult),
    .mem_wb_we(MemWbRegWrite), .mem_wb_rd(MemWbRd), .mem_wb_val(MemWbData),
    .val(ExStoreData)
  );
  assign BusB       = r.alu_src ? r.imm : ExStoreData;
  assign ALUCtrl    = r.alu_ctrl;
  assign ExValid    = r.valid;
  assign ExMemRead  = r.mem_read;
  assign ExMemWrite = r.mem_write;
  assign ExRegWrite = r.reg_write;
  assign ExMemToReg = r.mem_to_reg;
  assign ExRd       = r.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus a randomized run against a behavioural model of the ID/EX stage.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic        Clk = 0, Reset = 1, IdValid = 0, IdALUSrc = 0, Flush = 0;
  logic [4:0]  IdRn = 31, IdRm = 31, IdRd = 31, ExMemRd = 31, MemWbRd = 31;
  logic [63:0] IdRegOut1 = 0, IdRegOut2 = 0, IdImm = 0, ExMemResult = 0, MemWbData = 0;
  logic [3:0]  IdALUCtrl = 0;
  logic        IdMemRead = 0, IdMemWrite = 0, IdRegWrite = 0, IdMemToReg = 0;
  logic        ExMemRegWrite = 0, MemWbRegWrite = 0;
  logic [63:0] BusA, BusB, ExStoreData;
  logic [3:0]  ALUCtrl;
  logic        ExValid, ExMemRead, ExMemWrite, ExRegWrite, ExMemToReg, Stall;
  logic [4:0]  ExRd;
  int total = 0, bad = 0;

  id_ex_stage dut (
    .Clk(Clk), .Reset(Reset), .IdValid(IdValid), .IdRn(IdRn), .IdRm(IdRm), .IdRd(IdRd),
    .IdRegOut1(IdRegOut1), .IdRegOut2(IdRegOut2), .IdImm(IdImm), .IdALUSrc(IdALUSrc),
    .IdALUCtrl(IdALUCtrl), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
    .IdRegWrite(IdRegWrite), .IdMemToReg(IdMemToReg), .Flush(Flush),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .ExStoreData(ExStoreData),
    .ExValid(ExValid), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExRegWrite(ExRegWrite), .ExMemToReg(ExMemToReg), .ExRd(ExRd), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  // Reference model: what instruction sits in EX, tracked as plain fields.
  typedef struct {
    logic v; logic [4:0] rn, rm, rd; logic [63:0] a, b, imm;
    logic src; logic [3:0] op; logic mr, mw, rw, m2r;
  } ex_t;
  ex_t m;

  function automatic ex_t empty_slot();
    ex_t e;
    e = '{v: 0, rn: 31, rm: 31, rd: 31, a: 0, b: 0, imm: 0, src: 0, op: 0,
          mr: 0, mw: 0, rw: 0, m2r: 0};
    return e;
  endfunction

  function automatic logic ref_stall();
    return IdValid && m.v && m.mr && m.rd != 31 && (m.rd == IdRn || m.rd == IdRm);
  endfunction

  function automatic logic [63:0] ref_fwd(input logic [4:0] idx, input logic [63:0] rf);
    if (idx == 31) return rf;
    if (ExMemRegWrite && ExMemRd == idx) return ExMemResult;
    if (MemWbRegWrite && MemWbRd == idx) return MemWbData;
    return rf;
  endfunction

  always @(posedge Clk)
    if (Reset || Flush || ref_stall()) m <= empty_slot();
    else m <= '{v: IdValid, rn: IdRn, rm: IdRm, rd: IdRd, a: IdRegOut1, b: IdRegOut2,
                imm: IdImm, src: IdALUSrc, op: IdALUCtrl, mr: IdMemRead, mw: IdMemWrite,
                rw: IdRegWrite, m2r: IdMemToReg};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rn, rm, rd,
                        input logic [63:0] r1, r2, imm, input logic src,
                        input logic [3:0] op, input logic mr, mw, rw, m2r);
    IdValid = v; IdRn = rn; IdRm = rm; IdRd = rd; IdRegOut1 = r1; IdRegOut2 = r2;
    IdImm = imm; IdALUSrc = src; IdALUCtrl = op;
    IdMemRead = mr; IdMemWrite = mw; IdRegWrite = rw; IdMemToReg = m2r;
  endtask

  task automatic idle_fwd();
    ExMemRegWrite = 0; ExMemRd = 31; ExMemResult = 0;
    MemWbRegWrite = 0; MemWbRd = 31; MemWbData = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    idle_fwd();
    set_id(1, 3, 4, 5, 64'h1234, 64'h5678, 64'h9, 1, ALU_SUB, 1, 1, 1, 1);
    tick();
    tick();
    total += 8;
    if (ExValid !== 0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ExValid); end
    if ({ExMemRead, ExMemWrite, ExRegWrite, ExMemToReg} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {ExMemRead, ExMemWrite, ExRegWrite, ExMemToReg});
    end
    if (Stall !== 0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", Stall); end
    if (ALUCtrl !== 4'd0) begin bad++; $display("FAIL reset_aluctrl got=%h exp=0", ALUCtrl); end
    if (ExRd !== 5'd31) begin bad++; $display("FAIL reset_rd got=%0d exp=31", ExRd); end
    if (BusA !== 64'd0) begin bad++; $display("FAIL reset_busa got=%h exp=0", BusA); end
    if (BusB !== 64'd0) begin bad++; $display("FAIL reset_busb got=%h exp=0", BusB); end
    if (ExStoreData !== 64'd0) begin bad++; $display("FAIL reset_store got=%h exp=0", ExStoreData); end
    Reset = 0;
  endtask

  task automatic test_fwd_priority();
    set_id(1, 1, 3, 5, 64'hAAAA, 64'hBBBB, 0, 0, ALU_ADD, 0, 0, 1, 0);
    tick();
    set_id(0, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ExMemRegWrite = 1; ExMemRd = 1; ExMemResult = 64'h10;
    MemWbRegWrite = 1; MemWbRd = 1; MemWbData = 64'h20;
    #1;
    total += 5;
    if (BusA !== 64'h10) begin bad++; $display("FAIL fwd_exmem_wins got=%h exp=10", BusA); end
    if (ALUCtrl !== ALU_ADD) begin bad++; $display("FAIL fwd_aluctrl got=%h exp=2", ALUCtrl); end
    if (ExRd !== 5'd5) begin bad++; $display("FAIL fwd_rd got=%0d exp=5", ExRd); end
    ExMemRegWrite = 0;
    #1;
    if (BusA !== 64'h20) begin bad++; $display("FAIL fwd_memwb got=%h exp=20", BusA); end
    MemWbRegWrite = 0;
    #1;
    if (BusA !== 64'hAAAA) begin bad++; $display("FAIL fwd_none got=%h exp=aaaa", BusA); end
  endtask

  task automatic test_xzr();
    idle_fwd();
    set_id(1, 31, 31, 7, 0, 0, 0, 0, ALU_OR, 0, 0, 1, 0);
    tick();
    set_id(0, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ExMemRegWrite = 1; ExMemRd = 31; ExMemResult = 64'hFF;
    MemWbRegWrite = 1; MemWbRd = 31; MemWbData = 64'hEE;
    #1;
    total += 2;
    if (BusA !== 64'd0) begin bad++; $display("FAIL xzr_busa got=%h exp=0", BusA); end
    if (ExStoreData !== 64'd0) begin bad++; $display("FAIL xzr_store got=%h exp=0", ExStoreData); end
    idle_fwd();
  endtask

  task automatic test_back_to_back();
    set_id(1, 4, 31, 2, 64'h100, 0, 64'h8, 1, ALU_ADD, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 2, 9, 64'h3, 64'h4, 0, 0, ALU_ADD, 0, 0, 1, 0);
    #1;
    total += 7;
    if (Stall !== 1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", Stall); end
    tick();
    if (Stall !== 0) begin bad++; $display("FAIL lu_stall_once got=%0b exp=0", Stall); end
    if (ExValid !== 0 || ExRegWrite !== 0) begin
      bad++; $display("FAIL lu_bubble got=%0b%0b exp=00", ExValid, ExRegWrite);
    end
    tick();
    set_id(0, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MemWbRegWrite = 1; MemWbRd = 2; MemWbData = 64'h77;
    #1;
    if (ExValid !== 1) begin bad++; $display("FAIL lu_dep_valid got=%0b exp=1", ExValid); end
    if (ExRd !== 5'd9) begin bad++; $display("FAIL lu_dep_rd got=%0d exp=9", ExRd); end
    if (ExStoreData !== 64'h77) begin bad++; $display("FAIL lu_dep_fwd got=%h exp=77", ExStoreData); end
    if (BusA !== 64'h3) begin bad++; $display("FAIL lu_dep_busa got=%h exp=3", BusA); end
    idle_fwd();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 4, 31, 3, 0, 0, 64'h8, 1, ALU_ADD, 1, 0, 1, 1);
    tick();
    set_id(1, 3, 5, 6, 0, 0, 0, 0, ALU_ADD, 0, 0, 1, 0);
    #1;
    total += 2;
    if (Stall !== 1) begin bad++; $display("FAIL rst_stall_pre got=%0b exp=1", Stall); end
    Reset = 1;
    tick();
    Reset = 0;
    if (Stall !== 0 || ExValid !== 0) begin
      bad++; $display("FAIL rst_stall_post got=%0b%0b exp=00", Stall, ExValid);
    end
  endtask

  task automatic test_flush();
    set_id(1, 1, 2, 31, 0, 64'h5, 64'h10, 1, ALU_ADD, 0, 1, 0, 0);
    Flush = 1;
    tick();
    Flush = 0;
    set_id(0, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total += 1;
    if (ExMemWrite !== 0 || ExValid !== 0) begin
      bad++; $display("FAIL flush got=%0b%0b exp=00", ExMemWrite, ExValid);
    end
  endtask

  task automatic test_imm();
    set_id(1, 1, 6, 8, 0, 64'h1, 64'h8, 1, ALU_ADD, 0, 0, 1, 0);
    tick();
    set_id(0, 31, 31, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ExMemRegWrite = 1; ExMemRd = 6; ExMemResult = 64'h55;
    #1;
    total += 2;
    if (BusB !== 64'h8) begin bad++; $display("FAIL imm_busb got=%h exp=8", BusB); end
    if (ExStoreData !== 64'h55) begin bad++; $display("FAIL imm_store got=%h exp=55", ExStoreData); end
    idle_fwd();
  endtask

  function automatic logic [4:0] rand_reg();
    logic [4:0] x;
    x = 5'($urandom_range(0, 4));
    return x == 5'd4 ? 5'd31 : x;
  endfunction

  task automatic test_random();
    logic [63:0] ea, es, eb;
    for (int i = 0; i < 400; i++) begin
      tick();
      Reset = $urandom_range(0, 39) == 0;
      Flush = $urandom_range(0, 9) == 0;
      set_id(1'($urandom), rand_reg(), rand_reg(), rand_reg(),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), 4'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
             1'($urandom), 1'($urandom));
      ExMemRegWrite = 1'($urandom); ExMemRd = rand_reg(); ExMemResult = {$urandom, $urandom};
      MemWbRegWrite = 1'($urandom); MemWbRd = rand_reg(); MemWbData = {$urandom, $urandom};
      #1;
      ea = ref_fwd(m.rn, m.a);
      es = ref_fwd(m.rm, m.b);
      eb = m.src ? m.imm : es;
      total += 6;
      if (BusA !== ea) begin bad++; $display("FAIL rnd_busa i=%0d got=%h exp=%h", i, BusA, ea); end
      if (ExStoreData !== es) begin bad++; $display("FAIL rnd_store i=%0d got=%h exp=%h", i, ExStoreData, es); end
      if (BusB !== eb) begin bad++; $display("FAIL rnd_busb i=%0d got=%h exp=%h", i, BusB, eb); end
      if (Stall !== ref_stall()) begin bad++; $display("FAIL rnd_stall i=%0d got=%0b exp=%0b", i, Stall, ref_stall()); end
      if ({ExValid, ExMemRead, ExMemWrite, ExRegWrite, ExMemToReg} !== {m.v, m.mr, m.mw, m.rw, m.m2r}) begin
        bad++; $display("FAIL rnd_ctrl i=%0d got=%b exp=%b", i,
          {ExValid, ExMemRead, ExMemWrite, ExRegWrite, ExMemToReg}, {m.v, m.mr, m.mw, m.rw, m.m2r});
      end
      if ({ALUCtrl, ExRd} !== {m.op, m.rd}) begin
        bad++; $display("FAIL rnd_op_rd i=%0d got=%h/%0d exp=%h/%0d", i, ALUCtrl, ExRd, m.op, m.rd);
      end
    end
    Reset = 0;
    Flush = 0;
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_xzr();
    test_back_to_back();
    test_reset_mid_stall();
    test_flush();
    test_imm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
